pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl.sv | 157 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - pipeline hazard controller: memory freeze, halt, branch flush, load-use stall
// Controls the pipeline with a five-state Mealy FSM and a saturating debug counter of stall cycles.
module pipeline_hazard_ctrl #(
   parameter int MEM_LAT = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        id_valid,
   input  logic        id_uses_rn,
   input  logic        id_uses_rm,
   input  logic [2:0]  id_rn,
   input  logic [2:0]  id_rm,
   input  logic        ex_valid,
   input  logic        ex_loads,
   input  logic        ex_writes,
   input  logic        ex_halt,
   input  logic        br_taken,
   input  logic [2:0]  ex_rd,
   input  logic        mem_req,
   output logic        freeze,
   output logic        stall_if,
   output logic        stall_id,
   output logic        bubble_ex,
   output logic        flush,
   output logic        mem_done,
   output logic        halted,
   output logic [2:0]  state,
   output logic [15:0] stall_cycles
);

   localparam logic [2:0] S_RUN      = 3'd0;
   localparam logic [2:0] S_MEM_WAIT = 3'd1;
   localparam logic [2:0] S_MEM_DONE = 3'd2;
   localparam logic [2:0] S_FLUSH    = 3'd3;
   localparam logic [2:0] S_HALTED   = 3'd4;
   localparam logic [3:0] LAT_M1     = 4'(MEM_LAT - 1);

   logic [2:0]  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [15:0] stall_cycles_q, stall_cycles_d;
   logic        hazard;
   logic        start_mem;
   logic        do_halt;
   logic        do_branch;

   assign hazard = id_valid & ex_valid & ex_loads & ex_writes &
                   ((id_uses_rn & (id_rn == ex_rd)) | (id_uses_rm & (id_rm == ex_rd)));
   // MEM_DONE never restarts an access, so mem_req only counts in RUN.
   assign start_mem = (state_q == S_RUN) & mem_req;
   assign do_halt   = ex_valid & ex_halt;
   assign do_branch = ex_valid & br_taken;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= S_RUN;
         cnt_q          <= 4'd0;
         stall_cycles_q <= 16'd0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         stall_cycles_q <= stall_cycles_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_RUN, S_MEM_DONE: begin
            if (start_mem) begin
               if (MEM_LAT > 1) begin
                  state_d = S_MEM_WAIT;
                  cnt_d   = LAT_M1;
               end else begin
                  state_d = S_MEM_DONE;
               end
            end else if (do_halt) begin
               state_d = S_HALTED;
            end else if (do_branch) begin
               state_d = S_FLUSH;
            end else begin
               state_d = S_RUN;
            end
         end
         S_MEM_WAIT: begin
            if (cnt_q <= 4'd1) begin
               state_d = S_MEM_DONE;
               cnt_d   = 4'd0;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_FLUSH:  state_d = S_RUN;
         S_HALTED: state_d = S_HALTED;
         default:  state_d = S_RUN;
      endcase
   end

   always_comb begin
      freeze    = 1'b0;
      stall_if  = 1'b0;
      stall_id  = 1'b0;
      bubble_ex = 1'b0;
      flush     = 1'b0;
      mem_done  = 1'b0;
      halted    = 1'b0;
      if (!rst) begin
         case (state_q)
            S_RUN, S_MEM_DONE: begin
               mem_done = (state_q == S_MEM_DONE);
               if (start_mem) begin
                  freeze   = 1'b1;
                  stall_if = 1'b1;
                  stall_id = 1'b1;
               end else if (do_halt) begin
                  stall_if  = 1'b1;
                  stall_id  = 1'b1;
                  bubble_ex = 1'b1;
               end else if (do_branch) begin
                  flush     = 1'b1;
                  bubble_ex = 1'b1;
               end else if (hazard) begin
                  stall_if  = 1'b1;
                  stall_id  = 1'b1;
                  bubble_ex = 1'b1;
               end
            end
            S_MEM_WAIT: begin
               freeze   = 1'b1;
               stall_if = 1'b1;
               stall_id = 1'b1;
            end
            S_FLUSH: begin
               flush     = 1'b1;
               bubble_ex = 1'b1;
            end
            S_HALTED: begin
               stall_if  = 1'b1;
               stall_id  = 1'b1;
               bubble_ex = 1'b1;
               halted    = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      stall_cycles_d = stall_cycles_q;
      if ((state_q != S_HALTED) && (freeze || stall_if) && (stall_cycles_q != 16'hFFFF))
         stall_cycles_d = stall_cycles_q + 16'd1;
   end

   assign state        = state_q;
   assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed self-checking bench for pipeline_hazard_ctrl
// Control outputs are packed {freeze,stall_if,stall_id,bubble_ex,flush,mem_done,halted}.
module tb_pipeline_hazard_ctrl;

   logic        clk;
   logic        rst;
   logic        id_valid, id_uses_rn, id_uses_rm;
   logic [2:0]  id_rn, id_rm, ex_rd;
   logic        ex_valid, ex_loads, ex_writes, ex_halt, br_taken, mem_req;

   logic        freeze3, stall_if3, stall_id3, bubble_ex3, flush3, mem_done3, halted3;
   logic [2:0]  state3;
   logic [15:0] sc3;
   logic        freeze1, stall_if1, stall_id1, bubble_ex1, flush1, mem_done1, halted1;
   logic [2:0]  state1;
   logic [15:0] sc1;
   logic [6:0]  ctrl3, ctrl1;

   int n_tests = 0;
   int n_fail  = 0;

   localparam logic [6:0] C_NONE  = 7'b0000000;
   localparam logic [6:0] C_FRZ   = 7'b1110000;
   localparam logic [6:0] C_STALL = 7'b0111000;
   localparam logic [6:0] C_FLUSH = 7'b0001100;
   localparam logic [6:0] C_DONE  = 7'b0000010;
   localparam logic [6:0] C_DONEF = 7'b0001110;
   localparam logic [6:0] C_HALT  = 7'b0111001;

   assign ctrl3 = {freeze3, stall_if3, stall_id3, bubble_ex3, flush3, mem_done3, halted3};
   assign ctrl1 = {freeze1, stall_if1, stall_id1, bubble_ex1, flush1, mem_done1, halted1};

   pipeline_hazard_ctrl #(.MEM_LAT(3)) dut3 (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm),
      .id_rn(id_rn), .id_rm(id_rm), .ex_valid(ex_valid), .ex_loads(ex_loads), .ex_writes(ex_writes),
      .ex_halt(ex_halt), .br_taken(br_taken), .ex_rd(ex_rd), .mem_req(mem_req),
      .freeze(freeze3), .stall_if(stall_if3), .stall_id(stall_id3), .bubble_ex(bubble_ex3),
      .flush(flush3), .mem_done(mem_done3), .halted(halted3), .state(state3), .stall_cycles(sc3)
   );

   pipeline_hazard_ctrl #(.MEM_LAT(1)) dut1 (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm),
      .id_rn(id_rn), .id_rm(id_rm), .ex_valid(ex_valid), .ex_loads(ex_loads), .ex_writes(ex_writes),
      .ex_halt(ex_halt), .br_taken(br_taken), .ex_rd(ex_rd), .mem_req(mem_req),
      .freeze(freeze1), .stall_if(stall_if1), .stall_id(stall_id1), .bubble_ex(bubble_ex1),
      .flush(flush1), .mem_done(mem_done1), .halted(halted1), .state(state1), .stall_cycles(sc1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic settle;
      #1;
   endtask

   task automatic clear_inputs;
      id_valid = 0; id_uses_rn = 0; id_uses_rm = 0; id_rn = 0; id_rm = 0;
      ex_valid = 0; ex_loads = 0; ex_writes = 0; ex_halt = 0; br_taken = 0;
      ex_rd = 0; mem_req = 0;
   endtask

   task automatic set_hazard;
      ex_valid = 1; ex_loads = 1; ex_writes = 1; ex_rd = 3'd3;
      id_valid = 1; id_uses_rm = 1; id_rm = 3'd3;
   endtask

   initial begin
      clear_inputs();
      rst = 1'b1;
      mem_req = 1'b1;
      #2;
      check("rst_ctrl_zero", 32'(ctrl3), 32'(C_NONE));
      tick();
      rst = 1'b0;
      mem_req = 1'b0;
      settle();
      check("rst_state", 32'(state3), 32'd0);
      check("rst_sc", 32'(sc3), 32'd0);

      // load-use
      set_hazard();
      settle();
      check("lu_rm_hit", 32'(ctrl3), 32'(C_STALL));
      tick();
      id_rm = 3'd4;
      settle();
      check("lu_rm_miss", 32'(ctrl3), 32'(C_NONE));
      check("lu_sc1", 32'(sc3), 32'd1);
      check("lu_state", 32'(state3), 32'd0);
      tick();
      id_uses_rm = 0; id_uses_rn = 1; id_rn = 3'd3;
      settle();
      check("lu_rn_hit", 32'(ctrl3), 32'(C_STALL));
      tick();
      ex_writes = 0;
      settle();
      check("lu_nowrite", 32'(ctrl3), 32'(C_NONE));
      check("lu_sc2", 32'(sc3), 32'd2);
      clear_inputs();

      // memory wait for both latencies
      rst = 1'b1;
      tick();
      rst = 1'b0;
      mem_req = 1'b1;
      settle();
      check("mem3_c0", 32'(ctrl3), 32'(C_FRZ));
      check("mem1_c0", 32'(ctrl1), 32'(C_FRZ));
      tick();
      check("mem3_c1_state", 32'(state3), 32'd1);
      check("mem3_c1", 32'(ctrl3), 32'(C_FRZ));
      check("mem1_c1_state", 32'(state1), 32'd2);
      check("mem1_c1", 32'(ctrl1), 32'(C_DONE));
      check("mem1_sc", 32'(sc1), 32'd1);
      tick();
      check("mem3_c2", 32'(ctrl3), 32'(C_FRZ));
      tick();
      mem_req = 1'b0;
      settle();
      check("mem3_c3_state", 32'(state3), 32'd2);
      check("mem3_c3", 32'(ctrl3), 32'(C_DONE));
      tick();
      check("mem3_c4_state", 32'(state3), 32'd0);
      check("mem3_c4", 32'(ctrl3), 32'(C_NONE));
      check("mem3_sc", 32'(sc3), 32'd3);

      // memory request coinciding with a taken branch
      ex_valid = 1; br_taken = 1; mem_req = 1;
      settle();
      check("co_run", 32'(ctrl3), 32'(C_FRZ));
      tick();
      mem_req = 0;
      settle();
      check("co_wait", 32'(ctrl3), 32'(C_FRZ));
      tick();
      tick();
      check("co_done_state", 32'(state3), 32'd2);
      check("co_done", 32'(ctrl3), 32'(C_DONEF));
      tick();
      check("co_flush_state", 32'(state3), 32'd3);
      check("co_flush", 32'(ctrl3), 32'(C_FLUSH));
      br_taken = 0;
      tick();
      check("co_back_run", 32'(state3), 32'd0);
      check("co_sc", 32'(sc3), 32'd6);

      // branch, second branch during FLUSH ignored
      br_taken = 1;
      settle();
      check("br_c0", 32'(ctrl3), 32'(C_FLUSH));
      tick();
      check("br_c1_state", 32'(state3), 32'd3);
      check("br_c1", 32'(ctrl3), 32'(C_FLUSH));
      br_taken = 0;
      tick();
      check("br_c2_state", 32'(state3), 32'd0);
      check("br_c2", 32'(ctrl3), 32'(C_NONE));

      // halt beats branch, then sticky
      ex_halt = 1; br_taken = 1;
      settle();
      check("halt_entry", 32'(ctrl3), 32'(C_STALL));
      tick();
      for (int i = 0; i < 3; i++) begin
         mem_req = i[0]; br_taken = ~i[0]; ex_halt = 1'b0; ex_valid = i[1];
         settle();
         check("halt_sticky", 32'(ctrl3), 32'(C_HALT));
         check("halt_state", 32'(state3), 32'd4);
         tick();
      end
      check("halt_sc", 32'(sc3), 32'd7);
      rst = 1'b1;
      settle();
      check("rst_halt_ctrl", 32'(ctrl3), 32'(C_NONE));
      tick();
      rst = 1'b0;
      clear_inputs();
      settle();
      check("rst_halt_state", 32'(state3), 32'd0);
      check("rst_halt_sc", 32'(sc3), 32'd0);

      // reset in the middle of a memory wait
      mem_req = 1;
      tick();
      mem_req = 0;
      settle();
      check("midwait_state", 32'(state3), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      settle();
      check("midwait_rst_state", 32'(state3), 32'd0);
      check("midwait_rst_sc", 32'(sc3), 32'd0);
      check("midwait_rst_ctrl", 32'(ctrl3), 32'(C_NONE));

      // saturation
      set_hazard();
      repeat (65540) tick();
      check("sat_hold", 32'(sc3), 32'hFFFF);
      clear_inputs();
      tick();
      check("sat_after", 32'(sc3), 32'hFFFF);
      check("sat_state", 32'(state3), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
